// File: rtl/counter_frame_pkg.sv
// Shared types and constants for the counter snapshot framer.
// Frame layout: header, Cnt0 bytes MSB first, Cnt1 bytes MSB first, XOR checksum.
package counter_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        SUM
    } frame_state_t;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;

    // Total bytes on the wire for one frame: header + both counters + checksum.
    function automatic int frame_len(input int cnt_w);
        return 2 * (cnt_w / 8) + 2;
    endfunction

endpackage

// File: rtl/counter_frame_shifter.sv
// Snapshot register for both counters plus the running XOR checksum.
// The top byte of the snapshot is the data byte currently offered on the link.
module counter_frame_shifter
    import counter_frame_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic             shift,
    input  logic [CNT_W-1:0] cnt0,
    input  logic [CNT_W-1:0] cnt1,
    output logic [7:0]       top_byte,
    output logic [7:0]       checksum
);

    logic [2*CNT_W-1:0] snap;

    assign top_byte = snap[2*CNT_W-1 -: 8];

    // NOTE: non-blocking assignments so every register samples pre-edge values;
    // the checksum must fold in the byte that is leaving, not the next one.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            snap     <= '0;
            checksum <= 8'h00;
        end else if (load) begin
            snap     <= {cnt0, cnt1};
            checksum <= 8'h00;
        end else if (shift) begin
            snap     <= {snap[2*CNT_W-9:0], 8'h00};
            checksum <= checksum ^ top_byte;
        end
    end

endmodule

// File: rtl/counter_frame_tx.sv
// Frames a frozen snapshot of two counters onto an 8-bit valid/ready byte stream.
// All outputs come from registers or from a decode of the registered state.
module counter_frame_tx
    import counter_frame_pkg::*;
#(
    parameter int         CNT_W  = 64,
    parameter logic [7:0] HEADER = FRAME_HEADER
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [CNT_W-1:0] Cnt0,
    input  logic [CNT_W-1:0] Cnt1,
    input  logic             Req,
    output logic [7:0]       TxData,
    output logic             TxValid,
    input  logic             TxReady,
    output logic             Busy,
    output logic             Done,
    output logic             Overrun
);

    localparam int NDATA = frame_len(CNT_W) - 2;
    localparam int IDX_W = $clog2(NDATA);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDATA - 1);

    if (CNT_W % 8 != 0) begin : g_bad_width
        $error("CNT_W must be a multiple of 8");
    end

    frame_state_t     state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic             load, shift, done_nxt;
    logic [7:0]       top_byte, checksum;

    counter_frame_shifter #(.CNT_W(CNT_W)) u_shifter (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (load),
        .shift    (shift),
        .cnt0     (Cnt0),
        .cnt1     (Cnt1),
        .top_byte (top_byte),
        .checksum (checksum)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned
    // (otherwise a latch is inferred).
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: if (Req) begin
                load      = 1'b1;
                state_nxt = HDR;
            end
            HDR:  if (TxReady) state_nxt = DATA;
            DATA: if (TxReady) begin
                shift = 1'b1;
                if (idx == LAST_IDX) state_nxt = SUM;
            end
            SUM:  if (TxReady) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            idx     <= '0;
            Done    <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            if (load)       idx <= '0;
            else if (shift) idx <= idx + 1'b1;
            Done <= done_nxt;
            // Any request while a frame is on the wire is dropped and remembered.
            if (Req && state != IDLE) Overrun <= 1'b1;
        end
    end

    always_comb begin
        TxValid = (state != IDLE);
        Busy    = (state != IDLE);
        unique case (state)
            HDR:     TxData = HEADER;
            DATA:    TxData = top_byte;
            SUM:     TxData = checksum;
            default: TxData = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_counter_frame_tx.sv
// Scoreboard bench for counter_frame_tx: a behavioural model queues the expected
// frame bytes when a request is taken; outputs are compared on the falling edge.
module tb_counter_frame_tx;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [63:0] Cnt0, Cnt1;
    logic        Req;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        TxReady;
    logic        Busy;
    logic        Done;
    logic        Overrun;

    counter_frame_tx #(.CNT_W(64), .HEADER(8'hA5)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Cnt0    (Cnt0),
        .Cnt1    (Cnt1),
        .Req     (Req),
        .TxData  (TxData),
        .TxValid (TxValid),
        .TxReady (TxReady),
        .Busy    (Busy),
        .Done    (Done),
        .Overrun (Overrun)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] sb_q[$];
    int         m_rem  = 0;
    logic       m_done = 1'b0;
    logic       m_ovr  = 1'b0;
    logic       mon_en = 1'b0;

    task automatic push_frame(input logic [63:0] c0, input logic [63:0] c1);
        logic [7:0] sum, b;
        sum = 8'h00;
        sb_q.push_back(8'hA5);
        for (int i = 0; i < 8; i++) begin
            b = c0[63 - 8*i -: 8];
            sb_q.push_back(b);
            sum ^= b;
        end
        for (int i = 0; i < 8; i++) begin
            b = c1[63 - 8*i -: 8];
            sb_q.push_back(b);
            sum ^= b;
        end
        sb_q.push_back(sum);
    endtask

    always @(posedge Clk) begin
        logic [7:0] dropped;
        if (Reset) begin
            m_rem  = 0;
            m_done = 1'b0;
            m_ovr  = 1'b0;
            sb_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_rem != 0) begin
                if (Req) m_ovr = 1'b1;
                if (TxReady) begin
                    dropped = sb_q.pop_front();
                    m_rem--;
                    if (m_rem == 0) m_done = 1'b1;
                end
            end else if (Req) begin
                push_frame(Cnt0, Cnt1);
                m_rem = 18;
            end
        end
    end

    always @(negedge Clk) begin
        if (mon_en) begin
            check("txvalid", TxValid, m_rem != 0);
            check("busy", Busy, m_rem != 0);
            check("done", Done, m_done);
            check("overrun", Overrun, m_ovr);
            if (m_rem != 0 && sb_q.size() != 0) check("txdata", TxData, sb_q[0]);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_frame(input int budget, input bit rnd_ready);
        int n = 0;
        while (m_rem != 0 && n < budget) begin
            tick();
            if (rnd_ready) TxReady = 1'($urandom_range(0, 1));
            n++;
        end
        TxReady = 1'b1;
        check("frame_end", 64'(m_rem), 64'd0);
    endtask

    task automatic start_frame(input logic [63:0] c0, input logic [63:0] c1);
        Cnt0 = c0;
        Cnt1 = c1;
        Req  = 1'b1;
        tick();
        Req  = 1'b0;
    endtask

    initial begin
        Reset   = 1'b1;
        Req     = 1'b0;
        TxReady = 1'b1;
        Cnt0    = '0;
        Cnt1    = '0;
        tick();
        mon_en = 1'b1;
        tick();
        check("rst_txdata", TxData, 64'h00);
        check("rst_txvalid", TxValid, 64'd0);
        Reset = 1'b0;
        tick();

        // Basic frame, sink always ready
        start_frame(64'd1, 64'd4);
        wait_frame(40, 1'b0);
        tick();

        // Random back-pressure on a mixed pattern
        start_frame(64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF);
        wait_frame(400, 1'b1);
        tick();

        // Inputs change every cycle while the snapshot is in flight
        start_frame(64'hDEADBEEFCAFEF00D, 64'h8000000000000001);
        for (int i = 0; i < 60 && m_rem != 0; i++) begin
            Cnt0 = {$urandom, $urandom};
            Cnt1 = {$urandom, $urandom};
            TxReady = 1'($urandom_range(0, 1));
            tick();
        end
        wait_frame(40, 1'b0);
        tick();

        // Request held high: back-to-back frames, overrun after the first
        Cnt0 = 64'h1122334455667788;
        Cnt1 = 64'h99AABBCCDDEEFF00;
        Req  = 1'b1;
        for (int i = 0; i < 45; i++) begin
            if (i == 20) Cnt0 = 64'h0F0F0F0F0F0F0F0F;
            tick();
        end
        Req = 1'b0;
        wait_frame(40, 1'b0);
        tick();

        // Reset mid-frame after the fifth data byte
        start_frame(64'hA1A2A3A4A5A6A7A8, 64'hB1B2B3B4B5B6B7B8);
        for (int i = 0; i < 40 && m_rem > 12; i++) tick();
        Reset = 1'b1;
        tick();
        check("midrst_txvalid", TxValid, 64'd0);
        check("midrst_overrun", Overrun, 64'd0);
        Reset = 1'b0;
        tick();
        start_frame(64'h0000000000000080, 64'h7F00000000000000);
        wait_frame(40, 1'b0);
        tick();

        // Reset held with Req high, then the first request after release
        Reset = 1'b1;
        Req   = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        Reset = 1'b0;
        Cnt0  = 64'h5555AAAA5555AAAA;
        Cnt1  = 64'h0000FFFF0000FFFF;
        tick();
        Req = 1'b0;
        check("post_rst_hdr", TxData, 64'hA5);
        wait_frame(40, 1'b0);
        tick();
        tick();

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
